clq_dispatch: RTL
=================

CLQ_DISPATCH -- requirements
Module: clq_dispatch

Interface
REQ-001 Parameter NUM_BCP, default 4, number of BCP engines served (2..8).
REQ-002 Parameter DROP_CNT_W, default 16, width of the drop counter.
REQ-003 clk  input  1  the only clock; all state is updated on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-high (1 = in reset).
REQ-005 uc_lit  input  lit_t  unit literal from the UCQ arbiter (sign bit = MSB, magnitude below it).
REQ-006 uc_valid  input  1  uc_lit is valid.
REQ-007 uc_ready  output  1  block accepts uc_lit this cycle.
REQ-008 clq_uc_rqst  output  lit_t  literal presented to the CLQ head-node lookup.
REQ-009 clq_uc_rqst_valid  output  1  lookup request valid.
REQ-010 clq_init_ptr  input  ptr_t  head pointer returned combinationally by the CLQ.
REQ-011 clq_init_ptr_valid  input  1  a head node exists for the requested literal.
REQ-012 bcp_start  output  NUM_BCP  one-hot, one-cycle start pulse to an engine.
REQ-013 bcp_init_ptr  output  ptr_t  start pointer; valid only while bcp_start is non-zero.
REQ-014 bcp_lit  output  lit_t  literal being dispatched; valid only while bcp_start is non-zero.
REQ-015 bcp_done  input  NUM_BCP  one-cycle completion pulse per engine.
REQ-016 drop_cnt  output  DROP_CNT_W  count of literals discarded for lack of a head node.
REQ-017 idle  output  1  FSM is in IDLE and no engine is in flight.

Function
REQ-018 FSM states SHALL be IDLE, LOOKUP and DISPATCH.
REQ-019 IDLE: uc_ready=1; on uc_valid&uc_ready, capture uc_lit into hold_lit and go to LOOKUP.
REQ-020 LOOKUP: clq_uc_rqst=hold_lit and clq_uc_rqst_valid=1 for exactly one cycle; clq_init_ptr_valid is sampled in that same cycle.
REQ-021 LOOKUP with clq_init_ptr_valid=1: latch clq_init_ptr into hold_ptr, go to DISPATCH.
REQ-022 LOOKUP with clq_init_ptr_valid=0: increment drop_cnt, saturating at all-ones; go to IDLE.
REQ-023 Engine k is free when inflight[k]=0.
REQ-024 DISPATCH: select the first free engine searching from rr_ptr upward modulo NUM_BCP.
REQ-025 On that selection, pulse bcp_start[k] with bcp_init_ptr=hold_ptr and bcp_lit=hold_lit, set inflight[k], set rr_ptr=(k+1) mod NUM_BCP, and go to IDLE.
REQ-026 DISPATCH with no free engine: hold state, outputs and rr_ptr until an engine frees.
REQ-027 bcp_done[k] SHALL clear inflight[k] at the clock edge; that engine is free for selection in the following cycle, not the same one.
REQ-028 bcp_done on an engine that is not in flight SHALL be ignored.
REQ-029 Minimum latency: accept at cycle N, lookup at N+1, bcp_start at N+2.
REQ-030 uc_ready SHALL be 0 in LOOKUP and DISPATCH; throughput is at most one literal per 3 cycles.
REQ-031 clq_uc_rqst and bcp_lit/bcp_init_ptr SHALL be 0 whenever their valid/start is deasserted.

Reset
REQ-032 Reset values: FSM=IDLE, hold_lit=0, hold_ptr=0, inflight=0, rr_ptr=0, drop_cnt=0.
REQ-033 Reset output values: uc_ready=1, idle=1, all other outputs 0.
REQ-034 Reset asserted mid-operation SHALL abandon the held literal without any start pulse; in-flight tracking is lost.

Configuration
REQ-035 Macro CLQ_DISPATCH_DEDUP_EN SHALL be checked in IDLE, at capture.
REQ-036 When CLQ_DISPATCH_DEDUP_EN is defined, a captured literal equal to the bcp_lit of any in-flight engine (per-engine literal registers) SHALL be discarded, go to IDLE and increment dup_cnt (output, DROP_CNT_W, saturating).
REQ-037 When CLQ_DISPATCH_DEDUP_EN is undefined, no per-engine literal registers and no dup_cnt port exist; duplicates are dispatched normally.

Structure
REQ-038 lit_t, ptr_t, LIT_IDX_MAX and CLQ_DEPTH SHALL come from the shared SAT package; no local redefinition.
REQ-039 Round-robin selection SHALL be a sub-module, rr_arbiter (inputs req and base pointer; outputs one-hot grant and found flag).

Verification
REQ-040 Lit +3 with CLQ returning ptr 5 valid -> bcp_start=0001, ptr 5, lit +3, two cycles after accept.
REQ-041 Lit -7 with CLQ valid=0 -> no start, drop_cnt 0->1, uc_ready=1 at the next cycle.
REQ-042 Five literals dispatched with no done -> engines 0,1,2,3 started; 5th waits in DISPATCH; bcp_done[2] -> 5th starts on engine 2 the cycle after.
REQ-043 drop_cnt preset to 16'hFFFF by 65535 drops, then one more drop -> stays at 16'hFFFF.
REQ-044 Reset asserted in DISPATCH -> all outputs go to reset values immediately, with no bcp_start.
REQ-045 With DEDUP_EN, +4 in flight on engine 1, +4 sent again -> no start, dup_cnt=1; -4 -> dispatched.

Source files
------------

// File: rtl/clq_dispatch_pkg.sv
// clq_dispatch_pkg: shared SAT types and constants for the CLQ dispatch block.
package clq_dispatch_pkg;
    localparam int LIT_IDX_MAX = 127;
    localparam int CLQ_DEPTH = 64;
    typedef logic [$clog2(LIT_IDX_MAX+1):0] lit_t;
    typedef logic [$clog2(CLQ_DEPTH)-1:0] ptr_t;
    typedef enum logic [1:0] {IDLE, LOOKUP, DISPATCH} state_t;
endpackage

// File: rtl/clq_dispatch_rr_arbiter.sv
// rr_arbiter: grants the first requester at or above base, wrapping modulo N.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] base,
    output logic [N-1:0]         grant,
    output logic                 found
);
    int sel;
    // Second pass overrides the wrapped pick with the lowest index at or above base.
    always_comb begin
        sel = 0;
        found = 1'b0;
        for (int k = N-1; k >= 0; k--) if (req[k]) begin sel = k; found = 1'b1; end
        for (int k = N-1; k >= 0; k--) if (req[k] && k >= int'(base)) sel = k;
        grant = found ? N'(1) << sel : '0;
    end
endmodule

// File: rtl/clq_dispatch.sv
// clq_dispatch: looks up CLQ head nodes for unit literals and starts free BCP engines round-robin.
// Optional CLQ_DISPATCH_DEDUP_EN discards literals already in flight and counts them in dup_cnt.
module clq_dispatch
    import clq_dispatch_pkg::*;
#(
    parameter int NUM_BCP = 4,
    parameter int DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  lit_t                  uc_lit,
    input  logic                  uc_valid,
    output logic                  uc_ready,
    output lit_t                  clq_uc_rqst,
    output logic                  clq_uc_rqst_valid,
    input  ptr_t                  clq_init_ptr,
    input  logic                  clq_init_ptr_valid,
    output logic [NUM_BCP-1:0]    bcp_start,
    output ptr_t                  bcp_init_ptr,
    output lit_t                  bcp_lit,
    input  logic [NUM_BCP-1:0]    bcp_done,
    output logic [DROP_CNT_W-1:0] drop_cnt,
`ifdef CLQ_DISPATCH_DEDUP_EN
    output logic [DROP_CNT_W-1:0] dup_cnt,
`endif
    output logic                  idle
);
    localparam int PW = $clog2(NUM_BCP);

    state_t state, state_n;
    lit_t hold_lit;
    ptr_t hold_ptr;
    logic [NUM_BCP-1:0] inflight, grant;
    logic [PW-1:0] rr_ptr, rr_n;
    logic found, drop_inc, dup;

    rr_arbiter #(.N(NUM_BCP)) u_arb (
        .req(~inflight),
        .base(rr_ptr),
        .grant(grant),
        .found(found)
    );

`ifdef CLQ_DISPATCH_DEDUP_EN
    lit_t eng_lit [NUM_BCP];
    logic [NUM_BCP-1:0] match;
    always_comb begin
        match = '0;
        for (int k = 0; k < NUM_BCP; k++) match[k] = inflight[k] && eng_lit[k] == uc_lit;
        dup = |match;
    end
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            dup_cnt <= '0;
            for (int k = 0; k < NUM_BCP; k++) eng_lit[k] <= '0;
        end else begin
            if (state == IDLE && uc_valid && dup && dup_cnt != '1) dup_cnt <= dup_cnt + 1'b1;
            for (int k = 0; k < NUM_BCP; k++) if (bcp_start[k]) eng_lit[k] <= hold_lit;
        end
    end
`else
    assign dup = 1'b0;
`endif

    always_comb begin
        state_n = state;
        uc_ready = 1'b0;
        clq_uc_rqst = '0;
        clq_uc_rqst_valid = 1'b0;
        bcp_start = '0;
        bcp_init_ptr = '0;
        bcp_lit = '0;
        rr_n = rr_ptr;
        drop_inc = 1'b0;
        unique case (state)
            IDLE: begin
                uc_ready = 1'b1;
                state_n = (uc_valid && !dup) ? LOOKUP : IDLE;
            end
            LOOKUP: begin
                clq_uc_rqst = hold_lit;
                clq_uc_rqst_valid = 1'b1;
                drop_inc = !clq_init_ptr_valid;
                state_n = clq_init_ptr_valid ? DISPATCH : IDLE;
            end
            DISPATCH: if (found) begin
                bcp_start = grant;
                bcp_init_ptr = hold_ptr;
                bcp_lit = hold_lit;
                state_n = IDLE;
                for (int k = 0; k < NUM_BCP; k++)
                    if (grant[k]) rr_n = (k == NUM_BCP-1) ? '0 : PW'(k+1);
            end
            default: state_n = IDLE;
        endcase
        idle = state == IDLE && inflight == '0;
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
            hold_lit <= '0;
            hold_ptr <= '0;
            inflight <= '0;
            rr_ptr <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_n;
            if (uc_ready && uc_valid) hold_lit <= uc_lit;
            if (state == LOOKUP && clq_init_ptr_valid) hold_ptr <= clq_init_ptr;
            inflight <= (inflight & ~bcp_done) | bcp_start;
            rr_ptr <= rr_n;
            if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end
endmodule
